// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, PC source
// encodings, fetch states and default widths.
package busca_instrucao_pkg;

   localparam int PC_W_DEF    = 12;
   localparam int INSTR_W_DEF = 16;
   localparam int JMP_W_DEF   = 12;

   localparam logic [3:0] OP_JUMP   = 4'd11;
   localparam logic [3:0] OP_BRANCH = 4'd12;
   localparam logic [3:0] OP_MUL    = 4'd15;

   localparam logic [1:0] FCP_SEQ = 2'b00;
   localparam logic [1:0] FCP_ULA = 2'b01;
   localparam logic [1:0] FCP_JMP = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } estado_t;

endpackage

// File: rtl/busca_instrucao_calc_prox_pc.sv
// Combinational next-PC selection and PC write enable, driven by the
// controller's EscCP/EscCondCP/FonteCP decisions and the ALU zero flag.
module calc_prox_pc
   import busca_instrucao_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int JMP_W = JMP_W_DEF
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [JMP_W-1:0] jmp,
   input  logic             EscCP,
   input  logic             EscCondCP,
   input  logic [1:0]       FonteCP,
   input  logic             ula_zero,
   input  logic [PC_W-1:0]  ula_result,
   output logic [PC_W-1:0]  prox_pc,
   output logic             we
);

   logic [PC_W-1:0] jmp_ext;
   logic [PC_W-1:0] pc_mais1;

   // The jump field is fitted to the PC width whichever one is wider.
   generate
      if (JMP_W >= PC_W) begin : g_trunca
         assign jmp_ext = jmp[PC_W-1:0];
      end else begin : g_estende
         assign jmp_ext = {{(PC_W-JMP_W){1'b0}}, jmp};
      end
   endgenerate

   assign pc_mais1 = pc + PC_W'(1);
   assign we       = EscCP | EscCondCP;

   // A conditional write with zero clear is a branch not taken: it wins over FonteCP.
   always_comb begin
      prox_pc = pc_mais1;
      if (!(EscCondCP && !ula_zero)) begin
         case (FonteCP)
            FCP_ULA: prox_pc = ula_result;
            FCP_JMP: prox_pc = jmp_ext;
            default: prox_pc = pc_mais1;
         endcase
      end
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns PC and instruction register, fetches over a
// req/ack handshake and applies the controller's PC update when leaving EXEC.
module busca_instrucao
   import busca_instrucao_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter int              JMP_W    = JMP_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               stall,
   input  logic               EscCP,
   input  logic               EscCondCP,
   input  logic [1:0]         FonteCP,
   input  logic               ula_zero,
   input  logic [PC_W-1:0]    ula_result,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc
);

   estado_t         estado;
   logic [PC_W-1:0] prox_pc;
   logic            we;

   calc_prox_pc #(
      .PC_W  (PC_W),
      .JMP_W (JMP_W)
   ) u_calc_prox_pc (
      .pc         (pc),
      .jmp        (instr[JMP_W-1:0]),
      .EscCP      (EscCP),
      .EscCondCP  (EscCondCP),
      .FonteCP    (FonteCP),
      .ula_zero   (ula_zero),
      .ula_result (ula_result),
      .prox_pc    (prox_pc),
      .we         (we)
   );

   assign mem_addr = pc;
   assign opcode   = instr[INSTR_W-1:INSTR_W-4];

   // mem_req and instr_valid are registered alongside the state so they
   // change exactly on the transitions into and out of FETCH/EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado      <= IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         mem_req     <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         case (estado)
            IDLE: begin
               estado  <= FETCH;
               mem_req <= 1'b1;
            end
            FETCH: begin
               if (mem_ack) begin
                  instr       <= mem_rdata;
                  estado      <= EXEC;
                  mem_req     <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            EXEC: begin
               if (!stall) begin
                  if (we) begin
                     pc <= prox_pc;
                  end
                  estado      <= FETCH;
                  mem_req     <= 1'b1;
                  instr_valid <= 1'b0;
               end
            end
            default: begin
               estado      <= IDLE;
               mem_req     <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: directed scenarios followed by
// randomized instructions checked against a simple next-PC reference model.
module tb_busca_instrucao;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        stall;
   logic        EscCP;
   logic        EscCondCP;
   logic [1:0]  FonteCP;
   logic        ula_zero;
   logic [11:0] ula_result;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic        instr_valid;
   logic [11:0] pc;

   int tests = 0;
   int fails = 0;
   int mpc   = 0;

   busca_instrucao dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .stall       (stall),
      .EscCP       (EscCP),
      .EscCondCP   (EscCondCP),
      .FonteCP     (FonteCP),
      .ula_zero    (ula_zero),
      .ula_result  (ula_result),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   // Reference PC rule, stated directly in terms of the write/source decisions.
   function automatic int model_next(input int cur, input int word, input bit e, input bit ec,
                                     input int f, input bit z, input int res);
      if (!e && !ec) return cur;
      if (ec && !z) return (cur + 1) % 4096;
      if (f == 1) return res;
      if (f == 2) return word % 4096;
      return (cur + 1) % 4096;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one complete instruction starting in FETCH; updates the model PC.
   task automatic applyStimulus(input logic [15:0] word, input int lat, input int stalls,
                                input bit e, input bit ec, input logic [1:0] f,
                                input bit z, input logic [11:0] res);
      checkOutput("fetch_req", {31'b0, mem_req}, 1);
      checkOutput("fetch_addr", mem_addr, mpc);
      for (int i = 0; i < lat; i++) begin
         mem_ack = 1'b0;
         stall   = 1'($urandom);
         step();
         checkOutput("wait_req", {31'b0, mem_req}, 1);
         checkOutput("wait_addr", mem_addr, mpc);
         checkOutput("wait_valid", {31'b0, instr_valid}, 0);
      end
      mem_ack   = 1'b1;
      mem_rdata = word;
      step();
      mem_ack = 1'b0;
      checkOutput("instr", instr, word);
      checkOutput("opcode", opcode, word[15:12]);
      checkOutput("exec_valid", {31'b0, instr_valid}, 1);
      checkOutput("exec_req", {31'b0, mem_req}, 0);
      for (int i = 0; i < stalls; i++) begin
         stall      = 1'b1;
         EscCP      = 1'b1;
         FonteCP    = 2'($urandom);
         ula_result = 12'($urandom);
         mem_ack    = 1'($urandom);
         mem_rdata  = 16'($urandom);
         step();
         checkOutput("stall_pc", pc, mpc);
         checkOutput("stall_instr", instr, word);
         checkOutput("stall_valid", {31'b0, instr_valid}, 1);
         checkOutput("stall_req", {31'b0, mem_req}, 0);
      end
      stall      = 1'b0;
      EscCP      = e;
      EscCondCP  = ec;
      FonteCP    = f;
      ula_zero   = z;
      ula_result = res;
      step();
      mem_ack = 1'b0;
      mpc = model_next(mpc, int'(word), e, ec, int'(f), z, int'(res));
      checkOutput("next_pc", pc, mpc);
      checkOutput("next_req", {31'b0, mem_req}, 1);
      checkOutput("next_valid", {31'b0, instr_valid}, 0);
   endtask

   initial begin
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; stall = 1'b0;
      EscCP = 1'b0; EscCondCP = 1'b0; FonteCP = 2'b00; ula_zero = 1'b0; ula_result = '0;
      step();
      step();
      checkOutput("rst_pc", pc, 0);
      checkOutput("rst_instr", instr, 0);
      checkOutput("rst_opcode", opcode, 0);
      checkOutput("rst_req", {31'b0, mem_req}, 0);
      checkOutput("rst_valid", {31'b0, instr_valid}, 0);
      rst = 1'b0;
      step();
      mpc = 0;

      // Sequential fetch with three memory wait cycles
      applyStimulus(16'h1234, 3, 0, 1, 0, 2'b00, 0, 12'h000);
      // Reach pc=010, then jump to 05A
      applyStimulus(16'hB010, 0, 0, 1, 0, 2'b10, 0, 12'h000);
      applyStimulus(16'hB05A, 1, 0, 1, 0, 2'b10, 0, 12'h000);
      // Branch taken to 020, then from 030 not taken
      applyStimulus(16'hC000, 0, 0, 1, 1, 2'b01, 1, 12'h020);
      applyStimulus(16'hB030, 0, 0, 1, 0, 2'b10, 0, 12'h000);
      applyStimulus(16'hC000, 2, 0, 1, 1, 2'b01, 0, 12'h020);
      // Multiply stalled for three cycles
      applyStimulus(16'hF123, 0, 3, 1, 0, 2'b00, 0, 12'h000);
      // Wrap from FFF, then a no-write instruction re-fetches the same address
      applyStimulus(16'hBFFF, 0, 0, 1, 0, 2'b10, 0, 12'h000);
      applyStimulus(16'h0000, 1, 0, 1, 0, 2'b00, 0, 12'h000);
      applyStimulus(16'h2345, 0, 0, 0, 0, 2'b01, 1, 12'h777);
      applyStimulus(16'h3456, 0, 0, 1, 0, 2'b11, 0, 12'h777);

      // Reset in the middle of a fetch, with a late ack
      mem_ack = 1'b0;
      step();
      rst = 1'b1;
      #1;
      checkOutput("midrst_req", {31'b0, mem_req}, 0);
      checkOutput("midrst_pc", pc, 0);
      checkOutput("midrst_valid", {31'b0, instr_valid}, 0);
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      step();
      checkOutput("midrst_instr", instr, 0);
      rst = 1'b0;
      step();
      mem_ack = 1'b0;
      mpc = 0;
      checkOutput("late_ack_instr", instr, 0);
      checkOutput("late_ack_valid", {31'b0, instr_valid}, 0);
      applyStimulus(16'h1ABC, 0, 0, 1, 0, 2'b00, 0, 12'h000);

      // Randomized instructions
      for (int n = 0; n < 60; n++) begin
         applyStimulus(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 12'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
